// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_NUM_REGS = 32;

   // Register-zero handling
   localparam int unsigned ZERO_REG_OFF = 0;
   localparam int unsigned ZERO_REG_ON  = 1;

   // Read-port behaviour while its enable is low
   localparam int unsigned RD_HOLD_ZERO = 0;
   localparam int unsigned RD_HOLD_KEEP = 1;

   // Address width for a register file of n entries (n >= 2)
   function automatic int unsigned calc_aw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mp_regfile_if.sv
// Packed write/read bus between the pipeline stages and the register file.
interface mp_regfile_if
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2
);
   localparam int unsigned AW = calc_aw(NUM_REGS);

   logic [NUM_WR-1:0]        we;
   logic [NUM_WR*AW-1:0]     waddr;
   logic [NUM_WR*DATA_W-1:0] wdata;
   logic [NUM_RD-1:0]        re;
   logic [NUM_RD*AW-1:0]     raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rvalid;

   // Pipeline side: issues writes and read requests
   modport master (
      output we, waddr, wdata, re, raddr,
      input  rdata, rvalid
   );

   // Register file side
   modport slave (
      input  we, waddr, wdata, re, raddr,
      output rdata, rvalid
   );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: zero / out-of-range / bypass / storage select.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = ZERO_REG_ON,
   parameter int unsigned RD_HOLD  = RD_HOLD_ZERO,
   parameter int unsigned AW       = calc_aw(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     re_i,
   input  logic [AW-1:0]            raddr_i,
   input  logic [DATA_W-1:0]        rmem_i,
   input  logic [NUM_WR-1:0]        wact_i,
   input  logic [NUM_WR*AW-1:0]     waddr_i,
   input  logic [NUM_WR*DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic                     rvalid_o
);

   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q;

   // Next read data; later write ports override earlier ones on a bypass hit
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_d = '0;
         end else if (32'(raddr_i) >= NUM_REGS) begin
            rdata_d = '0;
         end else begin
            rdata_d = rmem_i;
            for (int i = 0; i < int'(NUM_WR); i++) begin
               if (wact_i[i] && (waddr_i[i*AW +: AW] == raddr_i)) begin
                  rdata_d = wdata_i[i*DATA_W +: DATA_W];
               end
            end
         end
      end else if (RD_HOLD == RD_HOLD_ZERO) begin
         rdata_d = '0;
      end
   end

   // Output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= re_i;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file: flop storage, write ports, NUM_RD registered reads.
module mp_regfile
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = ZERO_REG_ON,
   parameter int unsigned RD_HOLD  = RD_HOLD_ZERO
) (
   input  logic         clk,
   input  logic         rst,
   mp_regfile_if.slave  bus
);

   localparam int unsigned AW = calc_aw(NUM_REGS);

   logic [DATA_W-1:0]        mem_q [NUM_REGS];
   logic [NUM_WR-1:0]        wact_c;
   logic [NUM_RD*DATA_W-1:0] rdata_all;
   logic [NUM_RD-1:0]        rvalid_all;

   // Qualify writes: in range and not targeting a hardwired zero register
   always_comb begin
      logic [AW-1:0] wa;
      wact_c = '0;
      wa     = '0;
      for (int i = 0; i < int'(NUM_WR); i++) begin
         wa = bus.waddr[i*AW +: AW];
         if (bus.we[i] && (32'(wa) < NUM_REGS) &&
             !((ZERO_REG != 0) && (wa == '0))) begin
            wact_c[i] = 1'b1;
         end
      end
   end

   // Storage update; highest-index port wins on an address collision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < int'(NUM_REGS); k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_WR); i++) begin
            if (wact_c[i]) begin
               mem_q[bus.waddr[i*AW +: AW]] <= bus.wdata[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Read ports
   for (genvar j = 0; j < int'(NUM_RD); j++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rmem;

      assign ra   = bus.raddr[j*AW +: AW];
      assign rmem = (32'(ra) < NUM_REGS) ? mem_q[ra] : '0;

      rf_read_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG),
         .RD_HOLD  (RD_HOLD),
         .AW       (AW)
      ) u_rd (
         .clk      (clk),
         .rst      (rst),
         .re_i     (bus.re[j]),
         .raddr_i  (ra),
         .rmem_i   (rmem),
         .wact_i   (wact_c),
         .waddr_i  (bus.waddr),
         .wdata_i  (bus.wdata),
         .rdata_o  (rdata_all[j*DATA_W +: DATA_W]),
         .rvalid_o (rvalid_all[j])
      );
   end

   assign bus.rdata  = rdata_all;
   assign bus.rvalid = rvalid_all;

endmodule

// File: tb/tb_mp_regfile.sv
// Directed bench: default configuration (A) and ZERO_REG=0/RD_HOLD=1/24-entry (B).
module tb_mp_regfile;
   import regfile_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   mp_regfile_if #(.DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) ba ();
   mp_regfile_if #(.DATA_W(DW), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2)) bb ();

   mp_regfile #(
      .DATA_W(DW), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
      .ZERO_REG(ZERO_REG_ON), .RD_HOLD(RD_HOLD_ZERO)
   ) u_a (.clk(clk), .rst(rst), .bus(ba));

   mp_regfile #(
      .DATA_W(DW), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2),
      .ZERO_REG(ZERO_REG_OFF), .RD_HOLD(RD_HOLD_KEEP)
   ) u_b (.clk(clk), .rst(rst), .bus(bb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input int p, input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ba.we[p] = e; ba.waddr[p*AW +: AW] = a; ba.wdata[p*DW +: DW] = d;
   endtask
   task automatic rd_a(input int p, input logic e, input logic [AW-1:0] a);
      ba.re[p] = e; ba.raddr[p*AW +: AW] = a;
   endtask
   task automatic wr_b(input int p, input logic e, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bb.we[p] = e; bb.waddr[p*AW +: AW] = a; bb.wdata[p*DW +: DW] = d;
   endtask
   task automatic rd_b(input int p, input logic e, input logic [AW-1:0] a);
      bb.re[p] = e; bb.raddr[p*AW +: AW] = a;
   endtask

   function automatic logic [31:0] a_rd(input int p);
      return ba.rdata[p*DW +: DW];
   endfunction
   function automatic logic [31:0] b_rd(input int p);
      return bb.rdata[p*DW +: DW];
   endfunction

   initial begin
      rst = 1'b1;
      ba.we = '0; ba.waddr = '0; ba.wdata = '0; ba.re = '0; ba.raddr = '0;
      bb.we = '0; bb.waddr = '0; bb.wdata = '0; bb.re = '0; bb.raddr = '0;
      #1 rst = 1'b0;
      step(); step();
      check("reset_a_rdata0", a_rd(0), 32'h0);
      check("reset_a_rdata1", a_rd(1), 32'h0);
      check("reset_a_rvalid", 32'(ba.rvalid), 32'h0);
      #3 rst = 1'b1;

      // --- A: basic write then read on port 1
      wr_a(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      step();
      wr_a(0, 1'b0, 5'd0, 32'h0);
      rd_a(1, 1'b1, 5'd3);
      step();
      check("a_basic_rdata1", a_rd(1), 32'hDEAD_BEEF);
      check("a_basic_rvalid", 32'(ba.rvalid), 32'h2);
      check("a_basic_rdata0_idle", a_rd(0), 32'h0);

      // --- A: same-edge collision, port 1 wins, bypassed to port 0
      wr_a(0, 1'b1, 5'd7, 32'h11);
      wr_a(1, 1'b1, 5'd7, 32'h22);
      rd_a(0, 1'b1, 5'd7);
      rd_a(1, 1'b0, 5'd0);
      step();
      check("a_coll_bypass", a_rd(0), 32'h22);
      check("a_coll_rdata1_zero", a_rd(1), 32'h0);
      wr_a(0, 1'b0, 5'd0, 32'h0);
      wr_a(1, 1'b0, 5'd0, 32'h0);
      step();
      check("a_coll_stored", a_rd(0), 32'h22);

      // --- A: zero register drops writes, including the bypass path
      wr_a(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      rd_a(0, 1'b1, 5'd0);
      rd_a(1, 1'b1, 5'd0);
      step();
      check("a_r0_bypass_p0", a_rd(0), 32'h0);
      check("a_r0_bypass_p1", a_rd(1), 32'h0);
      check("a_r0_rvalid", 32'(ba.rvalid), 32'h3);
      wr_a(0, 1'b0, 5'd0, 32'h0);
      step();
      check("a_r0_read_p0", a_rd(0), 32'h0);
      check("a_r0_read_p1", a_rd(1), 32'h0);

      // --- A: read-disable clears data and strobe
      wr_a(0, 1'b1, 5'd4, 32'h55);
      rd_a(0, 1'b0, 5'd0);
      rd_a(1, 1'b0, 5'd0);
      step();
      wr_a(0, 1'b0, 5'd0, 32'h0);
      rd_a(0, 1'b1, 5'd4);
      step();
      check("a_r4_read", a_rd(0), 32'h55);
      rd_a(0, 1'b0, 5'd0);
      step();
      check("a_r4_disabled_zero", a_rd(0), 32'h0);
      check("a_r4_disabled_rvalid", 32'(ba.rvalid), 32'h0);

      // --- A: cross-port bypass and unwritten register
      wr_a(0, 1'b1, 5'd9, 32'hA5A5);
      rd_a(1, 1'b1, 5'd9);
      rd_a(0, 1'b1, 5'd10);
      step();
      check("a_xport_bypass", a_rd(1), 32'hA5A5);
      check("a_unwritten", a_rd(0), 32'h0);
      wr_a(0, 1'b0, 5'd0, 32'h0);

      // --- A: reset mid-stream, outputs clear with no clock edge
      rd_a(0, 1'b1, 5'd3);
      rd_a(1, 1'b1, 5'd7);
      step();
      check("a_pre_rst_p0", a_rd(0), 32'hDEAD_BEEF);
      check("a_pre_rst_p1", a_rd(1), 32'h22);
      #2 rst = 1'b0;
      #1;
      check("a_midrst_p0", a_rd(0), 32'h0);
      check("a_midrst_p1", a_rd(1), 32'h0);
      check("a_midrst_rvalid", 32'(ba.rvalid), 32'h0);
      #1 rst = 1'b1;
      rd_a(0, 1'b1, 5'd5);
      rd_a(1, 1'b1, 5'd31);
      step();
      check("a_post_rst_r5", a_rd(0), 32'h0);
      check("a_post_rst_r31", a_rd(1), 32'h0);
      check("a_post_rst_rvalid", 32'(ba.rvalid), 32'h3);
      rd_a(0, 1'b1, 5'd3);
      rd_a(1, 1'b1, 5'd7);
      step();
      check("a_cleared_r3", a_rd(0), 32'h0);
      check("a_cleared_r7", a_rd(1), 32'h0);
      rd_a(0, 1'b0, 5'd0);
      rd_a(1, 1'b0, 5'd0);

      // --- B: r0 is an ordinary register
      wr_b(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      rd_b(0, 1'b1, 5'd0);
      rd_b(1, 1'b1, 5'd0);
      step();
      check("b_r0_bypass_p0", b_rd(0), 32'hFFFF_FFFF);
      check("b_r0_bypass_p1", b_rd(1), 32'hFFFF_FFFF);
      wr_b(1, 1'b0, 5'd0, 32'h0);
      step();
      check("b_r0_stored", b_rd(0), 32'hFFFF_FFFF);

      // --- B: address beyond depth reads zero, even against a same-edge write
      wr_b(0, 1'b1, 5'd30, 32'hAB);
      rd_b(0, 1'b1, 5'd30);
      step();
      check("b_oor_bypass", b_rd(0), 32'h0);
      check("b_oor_other_port", b_rd(1), 32'hFFFF_FFFF);
      wr_b(0, 1'b0, 5'd0, 32'h0);
      step();
      check("b_oor_read", b_rd(0), 32'h0);

      // --- B: last valid entry
      wr_b(1, 1'b1, 5'd23, 32'h1234_5678);
      rd_b(0, 1'b1, 5'd23);
      step();
      check("b_r23_bypass", b_rd(0), 32'h1234_5678);
      wr_b(1, 1'b0, 5'd0, 32'h0);
      step();
      check("b_r23_stored", b_rd(0), 32'h1234_5678);

      // --- B: read-disable holds previous data
      wr_b(0, 1'b1, 5'd4, 32'h55);
      rd_b(0, 1'b0, 5'd0);
      rd_b(1, 1'b0, 5'd0);
      step();
      check("b_hold_prev", b_rd(0), 32'h1234_5678);
      check("b_hold_rvalid0", 32'(bb.rvalid), 32'h0);
      wr_b(0, 1'b0, 5'd0, 32'h0);
      rd_b(0, 1'b1, 5'd4);
      step();
      check("b_r4_read", b_rd(0), 32'h55);
      check("b_r4_rvalid", 32'(bb.rvalid), 32'h1);
      rd_b(0, 1'b0, 5'd0);
      step();
      check("b_r4_held", b_rd(0), 32'h55);
      check("b_r4_held_rvalid", 32'(bb.rvalid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
